// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, one bit per clock.
// Sum, carry-out and signed overflow are reported with a one-cycle done pulse.

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          // sum fills from the top so bit 0 lands in place after WIDTH shifts
          sum   <= {fa_s, sum[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout  <= fa_co;
            ovf   <= carry ^ fa_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): expectations queued at accept,
// checked when done pulses.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] res;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0, n_err = 0;
  int   cyc = 0;
  logic spc_en = 1'b0, spc_armed = 1'b0;
  int   last_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // result monitor + done spacing in back-to-back mode
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) chk("spur_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("res", {23'd0, cout, sum}, {23'd0, e.res});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
      if (spc_en) begin
        if (spc_armed) chk("spacing", cyc - last_done, 10);
        spc_armed = 1'b1;
        last_done = cyc;
      end else spc_armed = 1'b0;
    end
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t r;
    r.res = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.ovf = (x[W-1] == y[W-1]) && (r.res[W-1] != x[W-1]);
    return r;
  endfunction

  // waits at negedges for a rising busy, i.e. an accepted start
  task automatic wait_accept(output bit ok);
    logic prev;
    prev = busy;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy && !prev) begin ok = 1'b1; break; end
      prev = busy;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin @(negedge clk); t++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    bit ok;
    a = x; b = y; cin = c; start = 1'b1;
    wait_accept(ok);
    start = 1'b0;
    if (ok) sb.push_back(model(x, y, c));
    drain();
  endtask

  logic [W-1:0] corner [5];
  bit ok;
  int n, bc;

  initial begin
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
    corner[3] = 8'h80; corner[4] = 8'hFF;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {cout, ovf, sum}, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic add with latency and busy length
    a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
    wait_accept(ok);
    start = 1'b0;
    if (ok) sb.push_back(model(8'h35, 8'h4A, 1'b0));
    n = 0; bc = 1;
    while (!done && n < 20) begin
      @(negedge clk); n++;
      if (busy) bc++;
    end
    chk("latency", n, 8);
    chk("busy_len", bc, 8);
    @(negedge clk);
    chk("done_pulse", done, 0);
    repeat (5) @(negedge clk);
    chk("hold_sum", sum, 8'h7F);
    chk("hold_flags", {cout, ovf, busy, done}, 0);

    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);

    // requests during ADD ignored, operands isolated
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    wait_accept(ok);
    start = 1'b0;
    if (ok) sb.push_back(model(8'h10, 8'h20, 1'b0));
    @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); a = ~a; b = b ^ 8'h0F; cin = ~cin; end
    drain();
    repeat (10) @(negedge clk);
    chk("iso_sum", sum, 8'h30);

    // reset on the 4th ADD edge discards the operation
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    wait_accept(ok);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", {cout, ovf, done, sum}, 0);
    repeat (12) @(negedge clk);
    chk("mid_rst_idle", {busy, done}, 0);
    run_op(8'h01, 8'h02, 1'b0);
    chk("post_rst_sum", sum, 8'h03);

    // back-to-back sweeps with start held high
    spc_en = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int c = 0; c < 2; c++) begin
          a = corner[i]; b = corner[j]; cin = c[0];
          wait_accept(ok);
          if (ok) sb.push_back(model(corner[i], corner[j], c[0]));
        end
    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] x, y;
      logic c;
      x = W'($urandom_range(0, 255));
      y = W'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      a = x; b = y; cin = c;
      wait_accept(ok);
      if (ok) sb.push_back(model(x, y, c));
    end
    start = 1'b0;
    drain();
    spc_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
